// File: rtl/out_port_arb.sv
// out_port_arb: egress-side reader for one switch output port.
// Pulls packets from four per-ingress FIFOs and chooses between them
// round-robin. Each packet goes out on a registered valid/ready link.
// Optional build macro SW_ARB_STATS_EN adds per-input grant counters
// and the stat_sel/stat_cnt read port.
//
// state    | meaning
// ---------+--------------------------------------------------
// EMPTY    | output register holds nothing (out_valid=0)
// HELD     | output register holds a packet (out_valid=1)

`ifndef PKTW
`define PKTW 8
`endif

module out_port_arb #(
    parameter int NIN = 4,
    parameter int STW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NIN*(`PKTW+1)-1:0]  fifo_dout,
    input  logic [NIN-1:0]            fifo_empty,
    output logic [NIN-1:0]            fifo_re,
    output logic [`PKTW:0]            out_pkt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_src
`ifdef SW_ARB_STATS_EN
    ,
    input  logic [1:0]                stat_sel,
    output logic [STW-1:0]            stat_cnt
`endif
);

    localparam int PW = `PKTW + 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    logic [0:0]    state;
    logic [1:0]    rr_ptr;
    logic [1:0]    sel;
    logic [1:0]    cand;
    logic          any_req;
    logic          load;
    logic [PW-1:0] head [4];

    // Split the packed FIFO head bus into one word per input.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head[i] = fifo_dout[i*PW +: PW];
        end
    end

    // Round-robin search: first non-empty input starting at rr_ptr, wrapping 3->0.
    always_comb begin
        sel     = rr_ptr;
        cand    = rr_ptr;
        any_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!any_req && !fifo_empty[cand]) begin
                sel     = cand;
                any_req = 1'b1;
            end
        end
    end

    // Load whenever a source has data and the output register is free or draining.
    // Reset gates the pop so a FIFO is never read during a reset cycle.
    always_comb begin
        load = !rst && any_req && ((state == ST_EMPTY) || out_ready);
    end

    // One-hot pop strobe toward the selected FIFO.
    always_comb begin
        fifo_re = '0;
        if (load) begin
            fifo_re[sel] = 1'b1;
        end
    end

    // Output register and round-robin pointer; a load may overwrite an accepted packet in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            out_pkt <= '0;
            out_src <= 2'd0;
            rr_ptr  <= 2'd0;
        end else if (load) begin
            state   <= ST_HELD;
            out_pkt <= head[sel];
            out_src <= sel;
            rr_ptr  <= sel + 2'd1;
        end else if ((state == ST_HELD) && out_ready) begin
            state   <= ST_EMPTY;
        end
    end

    assign out_valid = (state == ST_HELD);

`ifdef SW_ARB_STATS_EN
    logic [STW-1:0] grant_cnt [4];

    // Saturating grant counters, one per input, bumped on each load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (load && (grant_cnt[sel] != {STW{1'b1}})) begin
            grant_cnt[sel] <= grant_cnt[sel] + 1'b1;
        end
    end

    assign stat_cnt = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_out_port_arb.sv
// Directed testbench for out_port_arb. FIFOs are modelled as queues in the
// bench; expected values are hand-derived from the arbitration rules.

`ifndef PKTW
`define PKTW 8
`endif

module tb_out_port_arb;

    localparam int W = `PKTW + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*W-1:0] fifo_dout = '0;
    logic [3:0]     fifo_empty = 4'b1111;
    logic [3:0]     fifo_re;
    logic [W-1:0]   out_pkt;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [1:0]     out_src;
`ifdef SW_ARB_STATS_EN
    logic [1:0]     stat_sel = 2'd0;
    logic [3:0]     stat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q [4][$];

`ifdef SW_ARB_STATS_EN
    out_port_arb #(.NIN(4), .STW(4)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .out_pkt(out_pkt), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src),
        .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );
`else
    out_port_arb dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .out_pkt(out_pkt), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src)
    );
`endif

    always #5 clk = ~clk;

    task automatic update_view();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_dout[i*W +: W] = (q[i].size() != 0) ? q[i][0] : '0;
        end
        #1;
    endtask

    function automatic bit all_empty();
        return (q[0].size() == 0) && (q[1].size() == 0) &&
               (q[2].size() == 0) && (q[3].size() == 0);
    endfunction

    // One clock: pop what the DUT strobed, then refresh the FIFO view.
    task automatic step();
        logic [3:0] re_s;
        re_s = fifo_re;
        n_checks++;
        if ((re_s & fifo_empty) !== 4'b0000) begin
            n_fail++;
            $display("FAIL empty_read: fifo_re=%b fifo_empty=%b", re_s, fifo_empty);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (re_s[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        update_view();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) q[i].push_back(W'(9'h0F0 + i));
        update_view();
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (fifo_re !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_re: got %b expected 0000", fifo_re);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_pkt !== '0) begin
            n_fail++;
            $display("FAIL reset_pkt: got %h expected 0", out_pkt);
        end
        n_checks++;
        if (out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_src: got %0d expected 0", out_src);
        end
        for (int i = 0; i < 4; i++) q[i].delete();
        update_view();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_full_contention();
        logic [1:0]   exp_src;
        logic [W-1:0] exp_pkt;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) q[i].push_back(W'(i*16 + j));
        update_view();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_src = 2'(k % 4);
            exp_pkt = W'((k % 4)*16 + k/4);
            n_checks++;
            if (fifo_re !== (4'b0001 << exp_src)) begin
                n_fail++;
                $display("FAIL contention_re[%0d]: got %b expected %b", k, fifo_re, 4'b0001 << exp_src);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== exp_src || out_pkt !== exp_pkt) begin
                n_fail++;
                $display("FAIL contention_out[%0d]: valid=%b src=%0d pkt=%h expected 1/%0d/%h",
                         k, out_valid, out_src, out_pkt, exp_src, exp_pkt);
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_drain: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_single_source();
        logic [W-1:0] pk [3];
        pk[0] = W'(9'h1A5);
        pk[1] = W'(9'h0B2);
        pk[2] = W'(9'h1C3);
        for (int k = 0; k < 3; k++) q[2].push_back(pk[k]);
        update_view();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (fifo_re !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_re[%0d]: got %b expected 0100", k, fifo_re);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd2 || out_pkt !== pk[k]) begin
                n_fail++;
                $display("FAIL single_out[%0d]: valid=%b src=%0d pkt=%h expected 1/2/%h",
                         k, out_valid, out_src, out_pkt, pk[k]);
            end
        end
        n_checks++;
        if (fifo_re !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle_re: got %b expected 0000", fifo_re);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: valid=%b expected 0", out_valid);
        end
    endtask

    // rr_ptr is 3 on entry (last grant went to input 2).
    task automatic test_backpressure();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) q[i].push_back(W'(9'h100 + i*16 + j));
        update_view();
        out_ready = 1'b0;
        n_checks++;
        if (fifo_re !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_first_re: got %b expected 1000", fifo_re);
        end
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (fifo_re !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall_re[%0d]: got %b expected 0000", c, fifo_re);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd3 || out_pkt !== W'(9'h130)) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b src=%0d pkt=%h expected 1/3/130",
                         c, out_valid, out_src, out_pkt);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (fifo_re !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_release_re: got %b expected 0001", fifo_re);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_pkt !== W'(9'h100)) begin
            n_fail++;
            $display("FAIL bp_release_out: valid=%b src=%0d pkt=%h expected 1/0/100",
                     out_valid, out_src, out_pkt);
        end
        for (int c = 0; c < 20 && !(all_empty() && !out_valid); c++) step();
        n_checks++;
        if (!all_empty() || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain_timeout: valid=%b remaining=%0d expected 0/0",
                     out_valid, q[0].size()+q[1].size()+q[2].size()+q[3].size());
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] exp_re  [3];
        logic [1:0] exp_src [3];
        exp_re[0] = 4'b0001; exp_src[0] = 2'd0;
        exp_re[1] = 4'b1000; exp_src[1] = 2'd3;
        exp_re[2] = 4'b0001; exp_src[2] = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        q[0].push_back(W'(9'h0A0));
        q[0].push_back(W'(9'h0A1));
        q[3].push_back(W'(9'h0D0));
        update_view();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (fifo_re !== exp_re[k]) begin
                n_fail++;
                $display("FAIL wrap_re[%0d]: got %b expected %b", k, fifo_re, exp_re[k]);
            end
            step();
            n_checks++;
            if (out_src !== exp_src[k] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_src[%0d]: src=%0d valid=%b expected %0d/1",
                         k, out_src, out_valid, exp_src[k]);
            end
        end
        n_checks++;
        if (out_pkt !== W'(9'h0A1)) begin
            n_fail++;
            $display("FAIL wrap_last_pkt: got %h expected 0a1", out_pkt);
        end
        step();
    endtask

`ifdef SW_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) q[1].push_back(W'(k));
        update_view();
        out_ready = 1'b1;
        for (int c = 0; c < 30 && !all_empty(); c++) step();
        step();
        stat_sel = 2'd1;
        #1;
        n_checks++;
        if (stat_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL stats_sat: got %0d expected 15", stat_cnt);
        end
        stat_sel = 2'd0;
        #1;
        n_checks++;
        if (stat_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL stats_idle: got %0d expected 0", stat_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stat_sel = 2'(i);
            #1;
            n_checks++;
            if (stat_cnt !== 4'd0) begin
                n_fail++;
                $display("FAIL stats_reset[%0d]: got %0d expected 0", i, stat_cnt);
            end
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_full_contention();
        test_single_source();
        test_backpressure();
        test_wrap_skip();
`ifdef SW_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/out_port_arb.md
Name: out_port_arb

Overview:
- Output-side reader for one switch egress port.
- Drains four per-input packet FIFOs (one per ingress port) using their re/empty/out interface.
- Arbitrates between them round-robin and presents one packet per cycle on a registered valid/ready egress link.
- One instance per output port; sits between the FIFO bank and the egress link.

Parameters:
- NIN, 4, number of source FIFOs. Fixed at 4 for this switch.
- STW, 16, width of the optional per-input grant counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_dout  input  4*(`PKTW+1)  head word of each FIFO; slice i = [i*(`PKTW+1) +: `PKTW+1]; combinational from the FIFO (valid same cycle).
- fifo_empty  input  4  empty flag per FIFO.
- fifo_re  output  4  read/pop strobe per FIFO; combinational, at most one bit set.
- out_pkt  output  `PKTW+1  registered egress packet.
- out_valid  output  1  out_pkt holds a packet.
- out_ready  input  1  downstream accepts out_pkt this cycle.
- out_src  output  2  index of the FIFO out_pkt came from.
- stat_sel  input  2  counter select (only with SW_ARB_STATS_EN).
- stat_cnt  output  STW  grant count of input stat_sel (only with SW_ARB_STATS_EN).

Behaviour:
- State:
  - output register: out_pkt, out_valid, out_src;
  - rr_ptr, 2 bits: next input with highest priority.
  - out_valid encodes the two states, EMPTY (0) and HELD (1).
- Reset (rst=1 at posedge): out_valid=0, out_pkt=0, out_src=0, rr_ptr=0. fifo_re is forced to 0000 whenever rst=1, combinationally. Reset mid-transfer drops the held packet; no FIFO is popped in that cycle.
- Selection:
  - sel = first i with fifo_empty[i]=0, searching rr_ptr, rr_ptr+1, ... mod 4.
  - Index arithmetic is 2-bit and wraps 3->0.
- load = !rst & (fifo_empty != 4'b1111) & (!out_valid | out_ready).
- fifo_re = load ? (1 << sel) : 4'b0000.
- Posedge, priority order:
  - if load: out_pkt <= fifo_dout[sel], out_src <= sel, out_valid <= 1, rr_ptr <= sel+1 mod 4.
  - else if out_valid & out_ready: out_valid <= 0; out_pkt and out_src keep their values.
  - else: hold all state.
- Transfer: a packet is transferred on a posedge where out_valid & out_ready. A simultaneous transfer and load replaces the register with no bubble.
- Backpressure: out_valid=1 & out_ready=0 -> fifo_re=0000; out_pkt and out_src are stable until accepted. rr_ptr does not advance.
- out_ready is don't-care while out_valid=0.
- Latency: head word at cycle N with fifo_re asserted -> on out_pkt, out_valid=1 from cycle N+1.
- Throughput: 1 packet/cycle with out_ready held high.
- Fairness: with all inputs continuously non-empty, grants go 0,1,2,3,0,...; no input waits more than 3 grants.
- Empty FIFOs are never read: fifo_re[i]=1 implies fifo_empty[i]=0. fifo_dout of unselected inputs is ignored.

Optional Feature:
- Macro: SW_ARB_STATS_EN.
- Defined:
  - four STW-bit grant counters, cleared by rst.
  - counter[sel] increments on every load and saturates at all-ones.
  - stat_cnt = counter[stat_sel], combinational.
  - stat_sel/stat_cnt ports exist.
- Undefined: no counters, and stat_sel/stat_cnt are absent from the port list. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with fifo_empty=0000 -> fifo_re=0000 every cycle; out_valid=0, out_pkt=0, out_src=0 after reset.
- Single source: only input 2 holds A,B,C; out_ready=1 -> fifo_re=0100 for 3 consecutive cycles; out_pkt=A,B,C on the following cycles with out_src=2; then out_valid=0.
- Full contention: all four FIFOs non-empty, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; no bubbles.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with all FIFOs non-empty -> fifo_re=0000, out_pkt/out_src unchanged. Raising out_ready -> load occurs in that same cycle with the next rr_ptr input.
- Wrap/skip: after a grant to 0 (rr_ptr=1), only inputs 0 and 3 non-empty -> next grants 3 then 0.
- Stats (SW_ARB_STATS_EN, STW=4): 20 grants to input 1, stat_sel=1 -> stat_cnt=15 (saturated). stat_sel=0 -> 0. After rst -> all counters read 0.
